// File: rtl/common_pkg.sv
// Shared writeback types: register file geometry, writeback entry
// layout and the writeback source tag.
package common;

  localparam int REGISTER_FILE_SIZE = 32;
  localparam int REG_ADDR_W = $clog2(REGISTER_FILE_SIZE);
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LSU
  } wb_src_e;

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// Synchronous circular FIFO used to buffer LSU load returns.
// Pointers carry an extra wrap bit so full/empty need no counter.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full = (wr_ptr[AW] != rd_ptr[AW]) &&
                (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Register file write port driver: ALU-first arbitration over a
// buffered LSU return path, with a load-pending scoreboard.
module writeback_arbiter
  import common::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int DATA_W       = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0]     lsu_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] query1_id,
  input  logic [REG_ADDR_W-1:0] query2_id,
  output logic                  query1_busy,
  output logic                  query2_busy,
  output logic                  stall_req,
  output logic                  rf_write_en,
  output logic [REG_ADDR_W-1:0] rf_write_id,
  output logic [DATA_W-1:0]     rf_write_data
);

  localparam int NREG = 2**REG_ADDR_W;
  localparam int CW = $clog2(STARVE_LIMIT+1);
  localparam int EW = REG_ADDR_W + DATA_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } entry_t;

  entry_t          head;
  entry_t          sel;
  wb_src_e         src;
  logic            pop;
  logic            full;
  logic            empty;
  logic [NREG-1:0] sb;
  logic [NREG-1:0] sb_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;

  assign lsu_ready = !full;

  wb_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (lsu_valid && lsu_ready),
    .push_data({lsu_rd, lsu_data}),
    .pop      (pop),
    .pop_data (head),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    src = WB_NONE;
    sel = '0;
    pop = 1'b0;
    if (alu_valid) begin
      src = WB_ALU;
      sel = {alu_rd, alu_data};
    end else if (!empty) begin
      src = WB_LSU;
      sel = head;
      pop = 1'b1;
    end
  end

  // Set is applied after clear so a same-edge collision leaves it pending.
  always_comb begin
    sb_nxt = sb;
    if (src == WB_LSU) sb_nxt[sel.rd] = 1'b0;
    if (issue_valid && issue_rd != '0) sb_nxt[issue_rd] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    if (!empty && !pop) begin
      cnt_nxt = cnt;
      if (cnt != CW'(STARVE_LIMIT)) cnt_nxt = cnt + CW'(1);
    end
  end

  assign query1_busy = sb[query1_id];
  assign query2_busy = sb[query2_id];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_write_en   <= 1'b0;
      rf_write_id   <= '0;
      rf_write_data <= '0;
      sb            <= '0;
      cnt           <= '0;
      stall_req     <= 1'b0;
    end else begin
      rf_write_en <= (src != WB_NONE) && (sel.rd != '0);
      if (src != WB_NONE && sel.rd != '0) begin
        rf_write_id   <= sel.rd;
        rf_write_data <= sel.data;
      end
      sb  <= sb_nxt;
      cnt <= cnt_nxt;
      if (empty) stall_req <= 1'b0;
      else if (cnt_nxt == CW'(STARVE_LIMIT)) stall_req <= 1'b1;
    end
  end

  a_no_alu_in_stall: assert property (
    @(posedge clk) disable iff (!reset_n) stall_req |-> !alu_valid
  );

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Producer-side driver of the register file write port: merges single-cycle ALU results and long-latency LSU load returns into one write per cycle.
- Buffers LSU returns in a small FIFO.
- Keeps a per-register pending scoreboard so the issue stage can detect RAW hazards on outstanding loads.
- Sits between the execute/memory stages and the register file, driving its write_en/write_id/write_data inputs.

Parameters:
- REG_ADDR_W, 5, register index width; the register count is 2**REG_ADDR_W.
- DATA_W, 32, write data width.
- FIFO_DEPTH, 4, LSU return buffer entries; must be a power of two, >= 2.
- STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may go undrained before stall_req is raised.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result present this cycle; no backpressure.
- alu_rd  in  REG_ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- lsu_valid  in  1  load return valid.
- lsu_ready  out  1  FIFO can accept a load return; equals !full.
- lsu_rd  in  REG_ADDR_W  load destination register.
- lsu_data  in  DATA_W  load data.
- issue_valid  in  1  a long-latency instruction was issued this cycle.
- issue_rd  in  REG_ADDR_W  its destination register; marks that register pending.
- query1_id, query2_id  in  REG_ADDR_W  source registers checked by the issue stage.
- query1_busy, query2_busy  out  1  queried register has an outstanding load.
- stall_req  out  1  request to upstream to withhold alu_valid.
- rf_write_en  out  1  register file write enable.
- rf_write_id  out  REG_ADDR_W  write index.
- rf_write_data  out  DATA_W  write data.

Behaviour:
- Reset (async, reset_n low):
  - rf_write_en=0, rf_write_id=0, rf_write_data=0.
  - FIFO empty, so lsu_ready=1.
  - Scoreboard all zero; starve counter 0; stall_req=0.
  - Reset mid-operation discards all buffered entries and pending bits.
- LSU push: occurs when lsu_valid && lsu_ready at a clock edge. With lsu_valid high and lsu_ready low, the source holds its data; no entry is lost or duplicated.
- Arbitration each cycle, ALU first:
  - If alu_valid, select the ALU result.
  - Otherwise, if the FIFO is non-empty, pop the head and select it.
  - Otherwise, select nothing.
- Write port timing:
  - The selection is registered onto rf_write_* at the next edge, giving 1-cycle latency from alu_valid, or from the pop cycle.
  - rf_write_en=1 only if a selection exists and its rd != 0. A rd=0 entry is still popped and consumed, but rf_write_en=0.
  - When rf_write_en=0, rf_write_id and rf_write_data hold their previous values.
- FIFO:
  - Circular buffer with REG_ADDR_W+DATA_W-wide entries.
  - Pointers carry one extra wrap bit; full and empty are derived from the pointers.
  - Push and pop in the same cycle when full: the pop occurs, the push is refused (lsu_ready was 0). Occupancy ends at FIFO_DEPTH-1.
  - Push and pop when empty: not allowed to bypass. The new entry is written and is popped the next cycle at the earliest.
- Scoreboard (2**REG_ADDR_W bits):
  - Set: bit[issue_rd] is set at the edge when issue_valid && issue_rd != 0.
  - Clear: bit[id] is cleared at the edge on which an LSU-sourced write with that id is registered onto rf_write_*.
  - Set and clear of the same bit at the same edge: set wins.
  - Bit 0 is never set.
  - queryN_busy = scoreboard[queryN_id], combinational. It is 0 for id 0.
  - It does not reflect a write being registered in the same cycle; the register file bypass covers that cycle.
- Starvation:
  - The counter increments on every cycle the FIFO is non-empty and no pop occurs. It resets to 0 on a pop or when the FIFO is empty.
  - stall_req is a registered output: it rises at the edge where the counter reaches STARVE_LIMIT, and falls at the edge after the FIFO becomes empty.
  - Upstream must hold alu_valid=0 while stall_req=1. If alu_valid is asserted anyway, the ALU still wins and a simulation assertion fires.
- WAW ordering between ALU and LSU results to the same register is upstream's responsibility, enforced through the scoreboard.

Decomposition:
- Shared package common:
  - REG_ADDR_W and DATA_W constants, consistent with REGISTER_FILE_SIZE.
  - wb_entry_t packed struct {rd, data}.
  - wb_src_e enum {WB_NONE, WB_ALU, WB_LSU}.
- One sub-module: wb_fifo, a parameterised sync FIFO (push/pop/full/empty, async active-low reset) instantiated for the LSU path.
- Arbiter, scoreboard and starve counter live in the top module.

Test Plan:
- Reset: after reset_n released, check rf_write_en=0, lsu_ready=1, stall_req=0, query1_busy=0 for ids 0..31.
- ALU only: alu_valid with rd=5, data=0xDEADBEEF at cycle N -> rf_write_en=1, id=5, data=0xDEADBEEF at cycle N+1. With rd=0 -> rf_write_en=0.
- Scoreboard clear:
  - issue rd=7 -> query1_busy(7)=1 from the next cycle.
  - lsu push rd=7, data=0x1234 with alu idle -> rf write (7, 0x1234) two cycles after the push.
  - busy(7) is cleared at that same edge.
- Priority and full FIFO:
  - Hold alu_valid=1 and push 4 LSU returns -> lsu_ready=0 after the 4th push.
  - A 5th lsu_valid is held and not lost.
  - Dropping alu_valid drains the entries in FIFO order, one per cycle; the 5th is then accepted.
- Starvation: FIFO holds 1 entry while alu_valid is held high -> stall_req=1 after 8 undrained cycles. Releasing alu_valid -> pop, FIFO empties, then stall_req=0.
- Set/clear collision and async reset:
  - issue rd=3 on the same edge as an LSU write to 3 -> busy(3) stays 1.
  - Assert reset_n low mid-drain -> outputs go to reset values immediately, without waiting for clk.
